// File: rtl/rtc_bus_engine_if.sv
// Command handshake and V3023 pad signals between the clock/alarm control
// logic (master) and the bus-cycle engine (slave).
interface rtc_bus_engine_if #(
    parameter int DW = 8
) ();
    logic          req;
    logic          cmd_wr;
    logic [DW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          ready;
    logic          done;
    logic [DW-1:0] rd_data;
    logic          init_done;

    logic          AD;
    logic          CS;
    logic          WR;
    logic          RD;
    logic [DW-1:0] ADout;
    logic          ad_oe;
    logic [DW-1:0] ADin;

    modport master (
        output req, cmd_wr, cmd_addr, cmd_data, ADin,
        input  ready, done, rd_data, init_done, AD, CS, WR, RD, ADout, ad_oe
    );

    modport slave (
        input  req, cmd_wr, cmd_addr, cmd_data, ADin,
        output ready, done, rd_data, init_done, AD, CS, WR, RD, ADout, ad_oe
    );
endinterface

// File: rtl/rtc_bus_engine.sv
// Bus-cycle engine for the V3023 multiplexed address/data port: runs full
// register write/read transactions and the power-up init table.
module rtc_bus_engine #(
    parameter int DW       = 8,
    parameter int T_SETUP  = 1,
    parameter int T_STROBE = 3,
    parameter int T_HOLD   = 1,
    parameter int T_GAP    = 5,
    parameter bit INIT_EN  = 1'b1
) (
    input logic             clki,
    input logic             rst,
    rtc_bus_engine_if.slave bus
);
    localparam int T_MAX_A = (T_SETUP > T_STROBE) ? T_SETUP : T_STROBE;
    localparam int T_MAX_B = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int CW      = $clog2(T_MAX + 1);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_ASET = 4'd1;
    localparam logic [3:0] S_ACS  = 4'd2;
    localparam logic [3:0] S_ASTB = 4'd3;
    localparam logic [3:0] S_AHLD = 4'd4;
    localparam logic [3:0] S_AREL = 4'd5;
    localparam logic [3:0] S_GAP1 = 4'd6;
    localparam logic [3:0] S_DCS  = 4'd7;
    localparam logic [3:0] S_DSTB = 4'd8;
    localparam logic [3:0] S_DHLD = 4'd9;
    localparam logic [3:0] S_DREL = 4'd10;
    localparam logic [3:0] S_GAP2 = 4'd11;

    // Counter load value on entry: the state lasts (value + 1) cycles.
    function automatic logic [CW-1:0] phase_len(input logic [3:0] s);
        case (s)
            S_ACS, S_DCS:   phase_len = CW'(T_SETUP - 1);
            S_ASTB, S_DSTB: phase_len = CW'(T_STROBE - 1);
            S_AHLD, S_DHLD: phase_len = CW'(T_HOLD - 1);
            S_GAP1, S_GAP2: phase_len = CW'(T_GAP - 1);
            default:        phase_len = '0;
        endcase
    endfunction

    function automatic logic [3:0] next_state(input logic [3:0] s);
        case (s)
            S_ASET:  next_state = S_ACS;
            S_ACS:   next_state = S_ASTB;
            S_ASTB:  next_state = S_AHLD;
            S_AHLD:  next_state = S_AREL;
            S_AREL:  next_state = S_GAP1;
            S_GAP1:  next_state = S_DCS;
            S_DCS:   next_state = S_DSTB;
            S_DSTB:  next_state = S_DHLD;
            S_DHLD:  next_state = S_DREL;
            S_DREL:  next_state = S_GAP2;
            default: next_state = S_IDLE;
        endcase
    endfunction

    function automatic logic [DW-1:0] init_addr(input logic [1:0] idx);
        case (idx)
            2'd0, 2'd1: init_addr = DW'(8'h02);
            2'd2:       init_addr = DW'(8'h10);
            default:    init_addr = DW'(8'h00);
        endcase
    endfunction

    function automatic logic [DW-1:0] init_data(input logic [1:0] idx);
        case (idx)
            2'd0:    init_data = DW'(8'h08);
            2'd2:    init_data = DW'(8'hD2);
            default: init_data = DW'(8'h00);
        endcase
    endfunction

    logic [3:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          init_busy_q, init_busy_d;
    logic [1:0]    init_idx_q, init_idx_d;
    logic          init_done_q, init_done_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic          ad_q, ad_d;
    logic          cs_q, cs_d;
    logic          wr_n_q, wr_n_d;
    logic          rd_n_q, rd_n_d;
    logic [DW-1:0] adout_q, adout_d;
    logic          ad_oe_q, ad_oe_d;
    logic          phase_end;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        data_d      = data_q;
        init_busy_d = init_busy_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        rd_data_d   = rd_data_q;
        phase_end   = (cnt_q == '0);
        if (!phase_end) cnt_d = cnt_q - 1'b1;

        case (state_q)
            S_IDLE: begin
                if (!init_done_q) begin
                    if (INIT_EN) begin
                        init_busy_d = 1'b1;
                        init_idx_d  = 2'd0;
                        wr_d        = 1'b1;
                        addr_d      = init_addr(2'd0);
                        data_d      = init_data(2'd0);
                        state_d     = S_ASET;
                    end else begin
                        init_done_d = 1'b1;
                    end
                end else if (ready_q && bus.req) begin
                    wr_d    = bus.cmd_wr;
                    addr_d  = bus.cmd_addr;
                    data_d  = bus.cmd_data;
                    state_d = S_ASET;
                end
            end
            S_GAP2: begin
                if (phase_end) begin
                    // Init entries chain straight into the next ASET without an idle cycle.
                    if (init_busy_q && init_idx_q != 2'd3) begin
                        init_idx_d = init_idx_q + 2'd1;
                        wr_d       = 1'b1;
                        addr_d     = init_addr(init_idx_q + 2'd1);
                        data_d     = init_data(init_idx_q + 2'd1);
                        state_d    = S_ASET;
                    end else begin
                        state_d = S_IDLE;
                        if (init_busy_q) begin
                            init_busy_d = 1'b0;
                            init_done_d = 1'b1;
                        end
                    end
                end
            end
            default: if (phase_end) state_d = next_state(state_q);
        endcase

        if (state_q == S_DSTB && phase_end && !wr_q) rd_data_d = bus.ADin;
        if (state_d != state_q) cnt_d = phase_len(state_d);
    end

    assign ready_d = (state_d == S_IDLE) && init_done_d;
    assign done_d  = (state_d == S_DREL) && !init_busy_q;

    // Pin values are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        ad_d    = 1'b1;
        cs_d    = 1'b1;
        wr_n_d  = 1'b1;
        rd_n_d  = 1'b1;
        adout_d = '1;
        ad_oe_d = 1'b0;
        case (state_d)
            S_ASET: ad_d = 1'b0;
            S_ACS: begin
                ad_d = 1'b0;
                cs_d = 1'b0;
            end
            S_ASTB: begin
                ad_d    = 1'b0;
                cs_d    = 1'b0;
                wr_n_d  = 1'b0;
                adout_d = addr_d;
                ad_oe_d = 1'b1;
            end
            S_AHLD: begin
                ad_d    = 1'b0;
                cs_d    = 1'b0;
                adout_d = addr_d;
                ad_oe_d = 1'b1;
            end
            S_AREL: begin
                adout_d = addr_d;
                ad_oe_d = 1'b1;
            end
            S_DCS: cs_d = 1'b0;
            S_DSTB: begin
                cs_d = 1'b0;
                if (wr_d) begin
                    wr_n_d  = 1'b0;
                    adout_d = data_d;
                    ad_oe_d = 1'b1;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            S_DHLD: begin
                cs_d = 1'b0;
                if (wr_d) begin
                    adout_d = data_d;
                    ad_oe_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clki) begin
        // NOTE: state and outputs update with non-blocking assignments only.
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            init_busy_q <= 1'b0;
            init_idx_q  <= 2'd0;
            init_done_q <= 1'b0;
            rd_data_q   <= '0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            ad_q        <= 1'b1;
            cs_q        <= 1'b1;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            adout_q     <= '1;
            ad_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            init_busy_q <= init_busy_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            rd_data_q   <= rd_data_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            ad_q        <= ad_d;
            cs_q        <= cs_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            adout_q     <= adout_d;
            ad_oe_q     <= ad_oe_d;
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.init_done = init_done_q;
    assign bus.AD        = ad_q;
    assign bus.CS        = cs_q;
    assign bus.WR        = wr_n_q;
    assign bus.RD        = rd_n_q;
    assign bus.ADout     = adout_q;
    assign bus.ad_oe     = ad_oe_q;
endmodule
